if_fetch_unit: RTL and testbench

//  Instruction fetch stage: owns the fetch PC and issues word requests to the instruction memory.

---
 rtl/if_fetch_unit_pkg.sv | 19 +
 rtl/if_fetch_unit_if.sv | 28 ++
 rtl/if_fetch_fifo.sv | 55 +++++
 rtl/if_fetch_unit.sv | 125 ++++++++++++
 tb/tb_if_fetch_unit.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types and constants: PC width, NOP encoding, FSM states, counter helper.
package if_fetch_unit_pkg;

  localparam int          PC_WIDTH = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response plus the IF/ID presentation and ID/EX control.
interface if_fetch_unit_if #(
  parameter int PC_WIDTH = if_fetch_unit_pkg::PC_WIDTH
) ();

  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_gnt;
  logic                imem_rvalid;
  logic [31:0]         imem_rdata;
  logic                stall;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                if_valid;
  logic [PC_WIDTH-1:0] if_pc;
  logic [31:0]         if_inst;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_inst,
    input  imem_gnt, imem_rvalid, imem_rdata, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_inst,
    output imem_gnt, imem_rvalid, imem_rdata, stall, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/if_fetch_fifo.sv
// Synchronous FIFO with clear; head is read straight from storage (registered, no bypass).
// Push and pop together on a full FIFO is legal; a lone push into a full FIFO is a fault.
module if_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];
  assign do_push  = push & ~clear;
  assign do_pop   = pop & ~empty & ~clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop && !clear));

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: issues in-order imem word requests, buffers responses, presents one instruction per cycle to ID.
// Redirect flushes the buffer and drops stale responses; IF_FETCH_PERF_EN adds fetched/dropped counters.
module if_fetch_unit #(
  parameter int                                     PC_WIDTH   = if_fetch_unit_pkg::PC_WIDTH,
  parameter logic [if_fetch_unit_pkg::PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                                     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_unit_if.master bus
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped
`endif
);

  import if_fetch_unit_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e        state_q;
  logic [PC_WIDTH-1:0] fetch_pc_q;
  logic [CW-1:0]       outst_q, outst_d, drop_q, drop_d;
  logic [CW-1:0]       buf_cnt, tag_cnt;
  logic [CW:0]         occupancy;
  logic                running, xfer, rv, accept, discard, redirect, pop;
  logic                buf_full, buf_empty, tag_full, tag_empty;
  logic [PC_WIDTH-1:0] tag_head;
  logic [PC_WIDTH+31:0] buf_head;

  assign redirect  = bus.redirect_valid;
  assign running   = (state_q != ST_IDLE);
  // Outstanding requests plus buffered words never exceed the buffer, so every response has a slot.
  assign occupancy = {1'b0, outst_q} + {1'b0, buf_cnt};
  assign bus.imem_req  = running && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign bus.imem_addr = fetch_pc_q;
  assign xfer    = bus.imem_req & bus.imem_gnt;
  assign rv      = bus.imem_rvalid & running & (outst_q != '0);
  assign accept  = rv & ~redirect & (drop_q == '0);
  assign discard = rv & ~accept;
  assign outst_d = outst_q + CW'(xfer) - CW'(rv);

  always_comb begin
    drop_d = drop_q;
    if (redirect)                   drop_d = outst_d;
    else if (rv && drop_q != '0)    drop_d = drop_q - CW'(1);
  end

  assign bus.if_valid = ~buf_empty;
  assign bus.if_pc    = buf_empty ? '0 : buf_head[PC_WIDTH+31:32];
  assign bus.if_inst  = buf_empty ? INST_NOP : buf_head[31:0];
  assign pop          = ~buf_empty & ~bus.stall & ~redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      if (state_q == ST_IDLE)                        state_q <= ST_RUN;
      else if (redirect)                             state_q <= (drop_d != '0) ? ST_FLUSH : ST_RUN;
      else if (state_q == ST_FLUSH && drop_d == '0)  state_q <= ST_RUN;

      if (redirect)  fetch_pc_q <= {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};
      else if (xfer) fetch_pc_q <= fetch_pc_q + PC_WIDTH'(4);

      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  // PCs of live requests only; stale requests are tracked purely by drop_q.
  if_fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PC_WIDTH)) u_tag_q (
    .clk      (clk),
    .rst      (rst),
    .push     (xfer & ~redirect),
    .push_dat (fetch_pc_q),
    .pop      (accept),
    .clear    (redirect),
    .head_dat (tag_head),
    .full     (tag_full),
    .empty    (tag_empty),
    .count    (tag_cnt)
  );

  if_fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PC_WIDTH+32)) u_inst_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_dat ({tag_head, bus.imem_rdata}),
    .pop      (pop),
    .clear    (redirect),
    .head_dat (buf_head),
    .full     (buf_full),
    .empty    (buf_empty),
    .count    (buf_cnt)
  );

  logic unused_status;
  assign unused_status = ^{tag_full, tag_empty, tag_cnt, buf_full, bus.redirect_pc[1:0]};

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_dropped_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= sat_add32(perf_fetched_q, {31'b0, pop});
      perf_dropped_q <= sat_add32(perf_dropped_q,
                                  {31'b0, discard} + (redirect ? 32'(buf_cnt) : 32'd0));
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: in-order imem responder with programmable latency, checks at negedge.
module tb_if_fetch_unit;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;
  int   cyc_n;
  int   lat;
  logic [31:0] q_addr[$];
  int          q_due[$];

  if_fetch_unit_if bus ();

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif

  if_fetch_unit #(.FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_dropped (perf_dropped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive inputs for the coming posedge, record any transfer, then advance to the next negedge.
  task automatic cyc(input logic g, input logic s, input logic r, input logic [31:0] p);
    bus.imem_gnt       = g;
    bus.stall          = s;
    bus.redirect_valid = r;
    bus.redirect_pc    = p;
    if (q_due.size() > 0 && q_due[0] <= cyc_n) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = inst_of(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
    end
    if (bus.imem_req && g) begin
      q_addr.push_back(bus.imem_addr);
      q_due.push_back(cyc_n + lat);
    end
    @(negedge clk);
    cyc_n++;
  endtask

  initial begin
    n_run = 0; n_fail = 0; cyc_n = 0; lat = 1;
    rst = 1'b1;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    @(negedge clk); @(negedge clk);

    chk1("rst_req",   bus.imem_req, 1'b0);
    chk1("rst_valid", bus.if_valid, 1'b0);
    chk ("rst_pc",    bus.if_pc,    32'h0);
    chk ("rst_inst",  bus.if_inst,  32'h0000_0013);

    // Start-up: gnt always, one-cycle response.
    rst = 1'b0;
    cyc(1, 0, 0, 0);
    chk1("c1_req", bus.imem_req, 1'b1);
    chk ("c1_addr", bus.imem_addr, 32'h0);
    cyc(1, 0, 0, 0);
    chk ("c2_addr", bus.imem_addr, 32'h4);
    chk1("c2_valid", bus.if_valid, 1'b0);
    cyc(1, 0, 0, 0);
    chk1("c3_valid", bus.if_valid, 1'b1);
    chk ("c3_pc",    bus.if_pc,    32'h0);
    chk ("c3_inst",  bus.if_inst,  inst_of(32'h0));
    chk1("c3_req",   bus.imem_req, 1'b0);
    cyc(1, 0, 0, 0);
    chk ("c4_pc",   bus.if_pc,     32'h4);
    chk ("c4_addr", bus.imem_addr, 32'h8);

    // Stall five cycles: buffer fills, outputs freeze, no request.
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, 0);
      chk1("stall_req",  bus.imem_req, 1'b0);
      chk ("stall_pc",   bus.if_pc,    32'h4);
      chk ("stall_inst", bus.if_inst,  inst_of(32'h4));
    end
    cyc(1, 0, 0, 0);
    chk1("unstall_valid", bus.if_valid, 1'b1);
    chk ("unstall_pc",    bus.if_pc,    32'h8);

    // Redirect to 0x100 with two responses in flight.
    lat = 3;
    cyc(1, 0, 0, 0);
    chk ("fl_addr16", bus.imem_addr, 32'h10);
    cyc(1, 0, 0, 0);
    chk1("fl_full_req", bus.imem_req, 1'b0);
    cyc(1, 0, 1, 32'h100);
    chk1("rd_valid", bus.if_valid, 1'b0);
    chk ("rd_nop",   bus.if_inst,  32'h0000_0013);
    cyc(1, 0, 0, 0);
    chk1("rd_req",  bus.imem_req,  1'b1);
    chk ("rd_addr", bus.imem_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      chk1("rd_drop_valid", bus.if_valid, 1'b0);
    end
    cyc(1, 0, 0, 0);
    chk1("rd_first_valid", bus.if_valid, 1'b1);
    chk ("rd_first_pc",    bus.if_pc,    32'h100);
    chk ("rd_first_inst",  bus.if_inst,  inst_of(32'h100));
    cyc(1, 0, 0, 0);
    chk ("rd_second_pc", bus.if_pc,     32'h104);
    chk ("rd_next_addr", bus.imem_addr, 32'h108);

    // Misaligned redirect landing on the same cycle as a response.
    lat = 1;
    cyc(1, 0, 0, 0);
    chk ("ma_pre_addr", bus.imem_addr, 32'h10C);
    cyc(1, 0, 1, 32'h203);
    chk ("ma_addr",  bus.imem_addr, 32'h200);
    chk1("ma_valid", bus.if_valid,  1'b0);
    cyc(1, 0, 0, 0);
    chk1("ma_valid2", bus.if_valid, 1'b0);
    cyc(1, 0, 0, 0);
    chk1("ma_first_valid", bus.if_valid, 1'b1);
    chk ("ma_first_pc",    bus.if_pc,    32'h200);

    // Wrap at top of address space, grant withheld four cycles.
    cyc(0, 0, 1, 32'hFFFF_FFFC);
    chk1("wr_req",  bus.imem_req,  1'b1);
    chk ("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0);
      chk1("hold_req",  bus.imem_req,  1'b1);
      chk ("hold_addr", bus.imem_addr, 32'hFFFF_FFFC);
    end
    cyc(1, 0, 0, 0);
    chk ("wrap_addr", bus.imem_addr, 32'h0);
    cyc(1, 0, 0, 0);
    chk ("wrap_pc", bus.if_pc, 32'hFFFF_FFFC);

    // Reset mid-operation, then a stray response during IDLE.
    rst = 1'b1;
    #1;
    chk1("mr_req",   bus.imem_req, 1'b0);
    chk1("mr_valid", bus.if_valid, 1'b0);
    chk ("mr_pc",    bus.if_pc,    32'h0);
    chk ("mr_inst",  bus.if_inst,  32'h0000_0013);
`ifdef IF_FETCH_PERF_EN
    chk ("mr_perf_f", perf_fetched, 32'h0);
    chk ("mr_perf_d", perf_dropped, 32'h0);
`endif
    q_addr.delete();
    q_due.delete();
    bus.imem_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc_n = 0;
    q_addr.push_back(32'h0000_0ABC);
    q_due.push_back(0);
    cyc(1, 0, 0, 0);
    chk ("mr_addr", bus.imem_addr, 32'h0);
    cyc(1, 0, 0, 0);
    chk1("mr_stray_valid", bus.if_valid, 1'b0);
    cyc(1, 0, 0, 0);
    chk1("mr_valid2", bus.if_valid, 1'b1);
    chk ("mr_pc2",    bus.if_pc,    32'h0);
    chk ("mr_inst2",  bus.if_inst,  inst_of(32'h0));

`ifdef IF_FETCH_PERF_EN
    cyc(1, 0, 0, 0);
    chk ("pf_fetched1", perf_fetched, 32'd1);
    cyc(1, 0, 1, 32'h40);
    chk ("pf_dropped1", perf_dropped, 32'd1);
    cyc(1, 0, 0, 0);
    chk ("pf_dropped2", perf_dropped, 32'd2);
    chk ("pf_fetched2", perf_fetched, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
